// File: rtl/tdt_jtag_host.sv
// JTAG host engine: turns TAP reset / IR scan / DR scan commands into TCLK/TMS/TDI
// waveforms and returns the TDO bits captured during the shift ticks.
module tdt_jtag_host #(
   parameter int unsigned CLK_DIV = 4,
   parameter int unsigned MAX_LEN = 64,
   parameter int unsigned LEN_W   = 7
) (
   input  logic               clk,
   input  logic               rst_b,
   input  logic               cmd_vld,
   output logic               cmd_ready,
   input  logic [1:0]         cmd_type,
   input  logic [LEN_W-1:0]   cmd_len,
   input  logic [MAX_LEN-1:0] cmd_data,
   output logic               rsp_vld,
   output logic [MAX_LEN-1:0] rsp_data,
   output logic               busy,
   output logic               host_dtm_tclk,
   output logic               host_dtm_tms,
   output logic               host_dtm_tdi,
   input  logic               dtm_host_tdo
);
   localparam int unsigned PH_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned CNT_W = LEN_W + 1;
   localparam int unsigned IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam logic [PH_W-1:0]  PH_LAST = PH_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(MAX_LEN);

   typedef enum logic [2:0] {
      S_IDLE, S_RST, S_PRE, S_SHIFT, S_POST, S_DONE
   } state_t;

   state_t             r_state, w_state_nx;
   logic [PH_W-1:0]    r_phase, w_phase_nx;
   logic [CNT_W-1:0]   r_tick, w_tick_nx;
   logic [CNT_W-1:0]   r_len, w_len_nx;
   logic               r_ir, w_ir_nx;
   logic [MAX_LEN-1:0] r_data, w_data_nx;
   logic [MAX_LEN-1:0] r_cap, w_cap_nx;
   logic [MAX_LEN-1:0] r_rsp_data, w_rsp_data_nx;
   logic               r_rsp_vld, w_rsp_vld_nx;
   logic               r_ready, w_ready_nx;
   logic               r_busy, w_busy_nx;
   logic               r_tclk, w_tclk_nx;
   logic               r_tms, w_tms_nx;
   logic               r_tdi, w_tdi_nx;
   logic [CNT_W-1:0]   w_len_eff;
   logic               w_xfer;

   // TMS level for a given tick of a given sequencing state
   function automatic logic tms_of(input state_t st, input logic [CNT_W-1:0] tick,
                                   input logic ir, input logic [CNT_W-1:0] len);
      case (st)
         S_RST:   return tick != CNT_W'(5);
         S_PRE:   return ir ? (tick < CNT_W'(2)) : (tick == '0);
         S_SHIFT: return tick == (len - CNT_W'(1));
         S_POST:  return tick == '0;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [CNT_W-1:0] last_of(input state_t st, input logic ir,
                                                input logic [CNT_W-1:0] len);
      case (st)
         S_RST:   return CNT_W'(5);
         S_PRE:   return ir ? CNT_W'(3) : CNT_W'(2);
         S_SHIFT: return len - CNT_W'(1);
         default: return CNT_W'(1);
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (!rst_b) begin
         r_state    <= S_IDLE;
         r_phase    <= '0;
         r_tick     <= '0;
         r_len      <= '0;
         r_ir       <= 1'b0;
         r_data     <= '0;
         r_cap      <= '0;
         r_rsp_data <= '0;
         r_rsp_vld  <= 1'b0;
         r_ready    <= 1'b1;
         r_busy     <= 1'b0;
         r_tclk     <= 1'b0;
         r_tms      <= 1'b1;
         r_tdi      <= 1'b0;
      end else begin
         r_state    <= w_state_nx;
         r_phase    <= w_phase_nx;
         r_tick     <= w_tick_nx;
         r_len      <= w_len_nx;
         r_ir       <= w_ir_nx;
         r_data     <= w_data_nx;
         r_cap      <= w_cap_nx;
         r_rsp_data <= w_rsp_data_nx;
         r_rsp_vld  <= w_rsp_vld_nx;
         r_ready    <= w_ready_nx;
         r_busy     <= w_busy_nx;
         r_tclk     <= w_tclk_nx;
         r_tms      <= w_tms_nx;
         r_tdi      <= w_tdi_nx;
      end
   end

   always_comb begin
      w_state_nx    = r_state;
      w_phase_nx    = r_phase;
      w_tick_nx     = r_tick;
      w_len_nx      = r_len;
      w_ir_nx       = r_ir;
      w_data_nx     = r_data;
      w_cap_nx      = r_cap;
      w_rsp_data_nx = r_rsp_data;
      w_rsp_vld_nx  = 1'b0;
      w_tclk_nx     = r_tclk;
      w_tms_nx      = r_tms;
      w_tdi_nx      = r_tdi;
      w_xfer        = cmd_vld && r_ready;

      if (cmd_len == '0)                 w_len_eff = CNT_W'(1);
      else if (CNT_W'(cmd_len) > LEN_MAX) w_len_eff = LEN_MAX;
      else                                w_len_eff = CNT_W'(cmd_len);

      if (w_xfer) begin
         // First tick of every sequence drives TMS=1; reserved type runs as TAP reset
         w_state_nx = ((cmd_type == 2'd1) || (cmd_type == 2'd2)) ? S_PRE : S_RST;
         w_ir_nx    = (cmd_type == 2'd1);
         w_len_nx   = w_len_eff;
         w_data_nx  = cmd_data;
         w_cap_nx   = '0;
         w_tick_nx  = '0;
         w_phase_nx = '0;
         w_tclk_nx  = 1'b0;
         w_tms_nx   = 1'b1;
         w_tdi_nx   = 1'b0;
      end else if (r_state == S_DONE) begin
         w_state_nx = S_IDLE;
      end else if (r_state != S_IDLE) begin
         if (r_phase != PH_LAST) begin
            w_phase_nx = r_phase + PH_W'(1);
         end else if (!r_tclk) begin
            w_phase_nx = '0;
            w_tclk_nx  = 1'b1;
            if (r_state == S_SHIFT) w_cap_nx[IDX_W'(r_tick)] = dtm_host_tdo;
         end else begin
            w_phase_nx = '0;
            w_tclk_nx  = 1'b0;
            if (r_tick == last_of(r_state, r_ir, r_len)) begin
               w_tick_nx = '0;
               case (r_state)
                  S_PRE:   w_state_nx = S_SHIFT;
                  S_SHIFT: w_state_nx = S_POST;
                  default: w_state_nx = S_DONE;
               endcase
            end else begin
               w_tick_nx = r_tick + CNT_W'(1);
            end
            if (w_state_nx == S_DONE) begin
               w_rsp_vld_nx  = 1'b1;
               w_rsp_data_nx = r_cap;
               w_tms_nx      = 1'b0;
               w_tdi_nx      = 1'b0;
            end else begin
               w_tms_nx = tms_of(w_state_nx, w_tick_nx, r_ir, r_len);
               w_tdi_nx = (w_state_nx == S_SHIFT) ? r_data[IDX_W'(w_tick_nx)] : 1'b0;
            end
         end
      end

      w_ready_nx = (w_state_nx == S_IDLE) || (w_state_nx == S_DONE);
      w_busy_nx  = !w_ready_nx;
   end

   assign cmd_ready     = r_ready;
   assign busy          = r_busy;
   assign rsp_vld       = r_rsp_vld;
   assign rsp_data      = r_rsp_data;
   assign host_dtm_tclk = r_tclk;
   assign host_dtm_tms  = r_tms;
   assign host_dtm_tdi  = r_tdi;

endmodule
